// File: rtl/tx_fifo.sv
// Transmit FIFO between the bus write port and the serial transmit engine.
// The count register drives full/empty/almost_full; overflow and underflow are sticky.
module tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_C);
    assign count       = count_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // A pop is taken whenever the FIFO holds data; a push is taken when there is
    // room or when a same-cycle pop frees a slot. Rejected requests only set the
    // sticky error flags. A push into an empty FIFO is not forwarded that cycle.
    always_comb begin
        rd_acc      = rd_en && !empty;
        wr_acc      = wr_en && (!full || rd_acc);
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_acc;
        count_d     = count_q;
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d    = rptr_q + 1'b1;
            rd_data_d = mem_q[rptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error event outranks clr_err in the same cycle.
        overflow_d  = (overflow_q && !clr_err) || (wr_en && full && !rd_acc);
        underflow_d = (underflow_q && !clr_err) || (rd_en && empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_tx_fifo.sv
// Bench for tx_fifo: directed test-plan sequences plus random traffic,
// all checked against a queue-based model of the FIFO's behaviour.
module tb_tx_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AF = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, overflow, underflow;
  logic [3:0]    count;

  tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard / reference model
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid, m_ovf, m_unf;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rd_data = '0;
    m_rd_valid = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [DW-1:0] wd, input logic re, input logic ce);
    int  sz;
    bit  racc, wacc;
    sz   = exp_q.size();
    racc = re && (sz > 0);
    wacc = we && ((sz < DEPTH) || racc);
    m_rd_valid = racc;
    if (racc) m_rd_data = exp_q.pop_front();
    if (wacc) exp_q.push_back(wd);
    if (ce) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (we && !wacc) m_ovf = 1'b1;
    if (re && sz == 0) m_unf = 1'b1;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = exp_q.size();
    check_eq({tag, ".count"}, 32'(count), 32'(sz));
    check_eq({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    check_eq({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
    check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AF));
    check_eq({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rd_valid));
    check_eq({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd_data));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check_eq({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // driver: called at a falling edge, applies inputs across one rising edge
  task automatic do_cycle(input string tag, input logic we, input logic [DW-1:0] wd,
                          input logic re, input logic ce);
    wr_en = we;
    wr_data = wd;
    rd_en = re;
    clr_err = ce;
    @(posedge clk);
    model_step(we, wd, re, ce);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
    model_reset();
    repeat (cycles) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    apply_reset(3);

    // fill and overflow
    for (int i = 0; i < 8; i++) do_cycle("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    check_eq("fill_count8", 32'(count), 32'd8);
    do_cycle("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
    check_eq("ovf_flag", 32'(overflow), 32'd1);

    // drain in order, underflow, clear
    for (int i = 0; i < 8; i++) begin
      do_cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("drain_data", 32'(rd_data), 32'(8'h10 + i));
    end
    do_cycle("unf", 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("unf_flag", 32'(underflow), 32'd1);
    do_cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // simultaneous at full
    for (int i = 0; i < 8; i++) do_cycle("fill2", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    do_cycle("simfull", 1'b1, 8'h30, 1'b1, 1'b0);
    check_eq("simfull_data", 32'(rd_data), 32'h20);
    for (int i = 0; i < 8; i++) do_cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("drain2_last", 32'(rd_data), 32'h30);

    // simultaneous at empty
    do_cycle("simempty", 1'b1, 8'h55, 1'b1, 1'b0);
    check_eq("simempty_cnt", 32'(count), 32'd1);
    do_cycle("pop55", 1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("pop55_data", 32'(rd_data), 32'h55);

    // wrap at occupancy 3, then asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) do_cycle("pre", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) do_cycle("wrap", 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h77;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_empty", 32'(empty), 32'd1);
    check_eq("arst_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    apply_reset(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      do_cycle("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom),
               1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
